// File: rtl/arb_req_stream_mux.sv
// Requester side of a request/acknowledge/grant arbiter, muxing PORTS ingress
// streams onto one registered output stream. Each port raises request while it
// has a frame pending, transfers while granted, and pulses acknowledge on the
// last accepted beat.
// Optional feature macro: ARB_REQ_GRANT_TIMEOUT_EN (abandons a granted frame
// whose source stalls for TIMEOUT_CYCLES and closes it with a zero-data beat).
module arb_req_stream_mux #(
    parameter int unsigned PORTS          = 4,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [PORTS-1:0]            s_tvalid,
    input  logic [PORTS-1:0]            s_tlast,
    output logic [PORTS-1:0]            s_tready,
    output logic [PORTS-1:0]            request,
    output logic [PORTS-1:0]            acknowledge,
    input  logic [PORTS-1:0]            grant,
    input  logic                        grant_valid,
    input  logic [$clog2(PORTS)-1:0]    grant_encoded,
    output logic [DATA_WIDTH-1:0]       m_tdata,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    output logic [$clog2(PORTS)-1:0]    m_tid,
    input  logic                        m_tready
`ifdef ARB_REQ_GRANT_TIMEOUT_EN
    ,
    output logic                        timeout_event
`endif
);

    localparam int unsigned IdxW = $clog2(PORTS);

    typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

    state_e                state_q [PORTS];
    // Set once a frame has had a beat accepted; clear at a frame boundary.
    logic [PORTS-1:0]      started_q;
    logic                  grant_ok;
    logic                  grant_hit;
    logic                  out_free;
    logic [PORTS-1:0]      port_grant;
    logic [PORTS-1:0]      granted;
    logic [PORTS-1:0]      accept;
    logic                  any_accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_last;

`ifdef ARB_REQ_GRANT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0]       cnt_q [PORTS];
    logic [PORTS-1:0]      stall;
    logic [PORTS-1:0]      fire;
    logic [IdxW-1:0]       fire_idx;
`else
    logic                  unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 1);
`endif

    // Grant qualification, per-port handshakes and the beat selected for output.
    always_comb begin
        grant_hit   = 1'b0;
        sel_data    = '0;
        sel_last    = 1'b0;
        port_grant  = '0;
        granted     = '0;
        s_tready    = '0;
        accept      = '0;
        acknowledge = '0;
        request     = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_encoded == IdxW'(i)) begin
                grant_hit = grant[i];
                sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last  = s_tlast[i];
            end
        end
        // Non-one-hot grants, or an encoding that disagrees with the vector, move nothing.
        grant_ok = grant_valid && (grant != '0) && ((grant & (grant - 1'b1)) == '0) && grant_hit;
        out_free = !m_tvalid || m_tready;
        for (int i = 0; i < PORTS; i++) begin
            port_grant[i]  = grant_ok && grant[i];
            granted[i]     = port_grant[i] && (state_q[i] == StXfer);
            s_tready[i]    = granted[i] && out_free;
            accept[i]      = s_tready[i] && s_tvalid[i];
            acknowledge[i] = accept[i] && s_tlast[i];
            request[i]     = (state_q[i] != StIdle);
        end
        any_accept = |accept;
`ifdef ARB_REQ_GRANT_TIMEOUT_EN
        stall    = '0;
        fire     = '0;
        fire_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            stall[i] = granted[i] && !s_tvalid[i] && started_q[i];
            // Wait for a free output slot so the closing beat is never dropped.
            fire[i]  = stall[i] && (cnt_q[i] == CntMax) && out_free;
            if (fire[i]) begin
                fire_idx = IdxW'(i);
            end
            acknowledge[i] = acknowledge[i] || fire[i];
        end
        timeout_event = |fire;
`endif
    end

    // Per-port request FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            started_q <= '0;
            for (int i = 0; i < PORTS; i++) begin
                state_q[i] <= StIdle;
            end
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                case (state_q[i])
                    StIdle: begin
                        if (s_tvalid[i]) begin
                            state_q[i] <= StReq;
                        end
                    end
                    StReq: begin
                        if (port_grant[i]) begin
                            state_q[i] <= StXfer;
                        end
                    end
                    StXfer: begin
                        if (accept[i]) begin
                            started_q[i] <= !s_tlast[i];
                        end
`ifdef ARB_REQ_GRANT_TIMEOUT_EN
                        if (fire[i]) begin
                            state_q[i]   <= StIdle;
                            started_q[i] <= 1'b0;
                        end else
`endif
                        if (!port_grant[i]) begin
                            // Grant lost: keep requesting if a frame is open or pending.
                            state_q[i] <= (started_q[i] || s_tvalid[i]) ? StReq : StIdle;
                        end else if (!started_q[i] && !s_tvalid[i]) begin
                            // Frame boundary with nothing queued behind it.
                            state_q[i] <= StIdle;
                        end
                    end
                    default: state_q[i] <= StIdle;
                endcase
            end
        end
    end

`ifdef ARB_REQ_GRANT_TIMEOUT_EN
    // Stall counters: count granted idle cycles mid-frame, saturating at the limit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (rst || accept[i] || fire[i]) begin
                cnt_q[i] <= '0;
            end else if (stall[i] && (cnt_q[i] != CntMax)) begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end
`endif

    // Single output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tdata  <= '0;
            m_tid    <= '0;
        end else if (any_accept) begin
            m_tvalid <= 1'b1;
            m_tlast  <= sel_last;
            m_tdata  <= sel_data;
            m_tid    <= grant_encoded;
`ifdef ARB_REQ_GRANT_TIMEOUT_EN
        end else if (|fire) begin
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b1;
            m_tdata  <= '0;
            m_tid    <= fire_idx;
`endif
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule
